// File: rtl/kij_pass_sequencer.sv
// kij_pass_sequencer
//
// Drives the 34-bit core instruction word through one complete kij pass:
//   1. weight words xmem -> L0, then L0 -> PEs (load), then a settle gap
//   2. activation words xmem -> L0
//   3. execute (L0 -> PE array)
//   4. drain OFIFO into the psum memory region owned by this kij
// The top-level controller iterates kij and pulses start once per pass.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse; begins a pass when idle
//   kij          kernel index, latched on an accepted start
//   ofifo_valid  OFIFO holds at least one psum word
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse at the end of a pass
//   inst         registered core instruction word
//
// inst bit map:
//   [33] acc        [32] CEN_pmem  [31] WEN_pmem  [30:20] A_pmem
//   [19] CEN_xmem   [18] WEN_xmem  [17:7] A_xmem
//   [6] ofifo_rd [5] ififo_wr [4] ififo_rd [3] l0_rd [2] l0_wr
//   [1] execute  [0] load
//   CEN/WEN are active-low. acc, ififo_wr and ififo_rd are never used.
//
// Handshake: start is a request sampled on a rising clk edge and is only
// honoured in IDLE; there is no acknowledge other than busy rising the next
// cycle, and a start seen while busy or during done is dropped. ofifo_valid
// is a level sampled on every rising edge in the drain phase: a high sample
// (with reads still owed) puts ofifo_rd on inst for the next cycle, and the
// matching pmem write follows in the cycle after that read.

module kij_pass_sequencer #(
    parameter int          col     = 8,
    parameter int          row     = 8,
    parameter int          len_nij = 36,
    parameter logic [10:0] w_base  = 11'h400,
    parameter logic [10:0] a_base  = 11'h000,
    parameter logic [10:0] p_base  = 11'h000,
    parameter int          gap     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
    input  logic        ofifo_valid,
    output logic        busy,
    output logic        done,
    output logic [33:0] inst
);

    if (col < 1 || row < 1 || len_nij < 1 || gap < 1) begin : g_param_check
        $error("kij_pass_sequencer: col, row, len_nij and gap must all be at least 1");
    end

    // Phase counter must hold the longest phase index (len_nij or col).
    localparam int CW = $clog2(len_nij + col + gap + 2);
    // Drain counters count up to len_nij inclusive.
    localparam int NW = $clog2(len_nij + 1);

    localparam logic [CW-1:0] C_COL       = CW'(col);
    localparam logic [CW-1:0] C_LEN       = CW'(len_nij);
    localparam logic [CW-1:0] C_LOAD_LAST = CW'(col - 1);
    localparam logic [CW-1:0] C_GAP_LAST  = CW'(gap - 1);
    localparam logic [CW-1:0] C_EXEC_LAST = CW'(len_nij - 1);
    localparam logic [NW-1:0] N_LEN       = NW'(len_nij);

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_CEN_X    = 19;
    localparam int B_OFIFO_RD = 6;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXECUTE  = 1;
    localparam int B_LOAD     = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_RD,
        S_W_LOAD,
        S_W_GAP,
        S_A_RD,
        S_EXEC,
        S_OF_RD,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NW-1:0]   rd_cnt, rd_cnt_n;
    logic [NW-1:0]   wr_cnt, wr_cnt_n;
    logic [3:0]      kij_q, kij_n;
    logic            rd_fire;
    logic            wr_fire;
    logic [33:0]     inst_n;
    logic            busy_n;
    logic            done_n;
    logic [10:0]     kij_off;

    // Psum region offset; deliberately 11-bit so it wraps with the pmem space.
    assign kij_off = 11'(kij_q) * 11'(len_nij);

    // ------------------------------------------------------------------
    // State register and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            kij_q  <= '0;
            inst   <= IDLE_WORD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rd_cnt <= rd_cnt_n;
            wr_cnt <= wr_cnt_n;
            kij_q  <= kij_n;
            inst   <= inst_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Each fixed phase lasts until cnt hits its last index;
    // cnt is cleared on every phase change.
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rd_cnt_n = rd_cnt;
        wr_cnt_n = wr_cnt;
        kij_n    = kij_q;
        rd_fire  = 1'b0;
        wr_fire  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_W_RD;
                    cnt_n    = '0;
                    rd_cnt_n = '0;
                    wr_cnt_n = '0;
                    kij_n    = kij;
                end
            end
            // col reads plus one extra cycle for the last L0 write.
            S_W_RD: begin
                if (cnt == C_COL) begin
                    state_n = S_W_LOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_W_LOAD: begin
                if (cnt == C_LOAD_LAST) begin
                    state_n = S_W_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_W_GAP: begin
                if (cnt == C_GAP_LAST) begin
                    state_n = S_A_RD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_A_RD: begin
                if (cnt == C_LEN) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_EXEC: begin
                if (cnt == C_EXEC_LAST) begin
                    state_n = S_OF_RD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            // wr_cnt == len_nij means the final write is on inst this cycle.
            S_OF_RD: begin
                if (wr_cnt == N_LEN) begin
                    state_n = S_DONE;
                end else begin
                    // A read on inst now becomes a pmem write next cycle.
                    wr_fire = inst[B_OFIFO_RD];
                    if (wr_fire) begin
                        wr_cnt_n = wr_cnt + NW'(1);
                    end
                    rd_fire = ofifo_valid && (rd_cnt < N_LEN);
                    if (rd_fire) begin
                        rd_cnt_n = rd_cnt + NW'(1);
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode for the cycle about to start (state_n / cnt_n), so that
    // inst, busy and done come straight from flops.
    // ------------------------------------------------------------------
    always_comb begin
        inst_n = IDLE_WORD;

        unique case (state_n)
            S_W_RD: begin
                if (cnt_n < C_COL) begin
                    inst_n[B_CEN_X] = 1'b0;
                    inst_n[17:7]    = w_base + 11'(cnt_n);
                end
                // SRAM data appears one cycle after the read address.
                inst_n[B_L0_WR] = (cnt_n != '0);
            end
            S_W_LOAD: begin
                inst_n[B_LOAD]  = 1'b1;
                inst_n[B_L0_RD] = 1'b1;
            end
            S_W_GAP: begin
                inst_n[B_LOAD] = 1'b1;
            end
            S_A_RD: begin
                if (cnt_n < C_LEN) begin
                    inst_n[B_CEN_X] = 1'b0;
                    inst_n[17:7]    = a_base + 11'(cnt_n);
                end
                inst_n[B_L0_WR] = (cnt_n != '0);
            end
            S_EXEC: begin
                inst_n[B_EXECUTE] = 1'b1;
                inst_n[B_L0_RD]   = 1'b1;
            end
            S_OF_RD: begin
                inst_n[B_OFIFO_RD] = rd_fire;
                if (wr_fire) begin
                    inst_n[B_CEN_P] = 1'b0;
                    inst_n[B_WEN_P] = 1'b0;
                    inst_n[30:20]   = p_base + kij_off + 11'(wr_cnt);
                end
            end
            default: begin
                inst_n = IDLE_WORD;
            end
        endcase

        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_kij_pass_sequencer.sv
module tb_kij_pass_sequencer;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam int LEN = 36;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  kij;
  logic        ofifo_valid;
  logic        busy;
  logic        done;
  logic [33:0] inst;

  always #5 clk = ~clk;

  kij_pass_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .kij         (kij),
    .ofifo_valid (ofifo_valid),
    .busy        (busy),
    .done        (done),
    .inst        (inst)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pass timeline measured in cycles after the accepted start:
  //   1..9 weight reads, 10..17 load+l0_rd, 18..27 load, 28..64 act reads,
  //   65..100 execute, 101.. drain.
  function automatic logic [33:0] fixed_word(input int t);
    logic [33:0] w;
    w = IDLE_W;
    if (t <= 9) begin
      if (t <= 8) begin
        w[19] = 1'b0;
        w[17:7] = 11'(32'h400 + t - 1);
      end
      w[2] = (t >= 2);
    end else if (t <= 17) begin
      w[0] = 1'b1;
      w[3] = 1'b1;
    end else if (t <= 27) begin
      w[0] = 1'b1;
    end else if (t <= 64) begin
      if (t <= 63) begin
        w[19] = 1'b0;
        w[17:7] = 11'(t - 28);
      end
      w[2] = (t >= 29);
    end else begin
      w[1] = 1'b1;
      w[3] = 1'b1;
    end
    return w;
  endfunction

  int          m_mode;   // 0 idle, 1 in pass, 2 done cycle
  int          m_t;
  int          m_kij;
  int          m_rd;
  int          m_wr;
  logic [33:0] exp_inst;
  logic        exp_busy;
  logic        exp_done;

  always @(posedge clk or posedge reset) begin : model
    logic [33:0] nw;
    if (reset) begin
      m_mode = 0;
      exp_inst = IDLE_W;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (start) begin
            m_mode = 1;
            m_t = 1;
            m_kij = int'(kij);
            m_rd = 0;
            m_wr = 0;
            exp_inst = fixed_word(1);
            exp_busy = 1'b1;
          end
        end
        2: begin
          m_mode = 0;
          exp_done = 1'b0;
        end
        default: begin
          if (m_t > 100 && m_wr == LEN) begin
            m_mode = 2;
            exp_inst = IDLE_W;
            exp_busy = 1'b0;
            exp_done = 1'b1;
          end else if (m_t < 100) begin
            exp_inst = fixed_word(m_t + 1);
          end else begin
            nw = IDLE_W;
            if (m_t > 100) begin
              if (exp_inst[6]) begin
                nw[32] = 1'b0;
                nw[31] = 1'b0;
                nw[30:20] = 11'(m_kij * LEN + m_wr);
                m_wr++;
              end
              if (ofifo_valid && m_rd < LEN) begin
                nw[6] = 1'b1;
                m_rd++;
              end
            end
            exp_inst = nw;
          end
          m_t++;
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      chk("inst", inst, exp_inst);
      chk("busy", {33'd0, busy}, {33'd0, exp_busy});
      chk("done", {33'd0, done}, {33'd0, exp_done});
    end
  end

  // ---------------- activity monitor (for literal pins) ----------------
  int          n_xrd, n_l0wr, n_load, n_l0rd, n_exec, n_ofrd, n_pwr, n_done;
  int          first_l0wr, first_exec, last_exec, first_ofrd, first_pwr, done_idx;
  logic [10:0] a_x_first, first_paddr, last_paddr;

  always @(negedge clk) begin : monitor
    int idx;
    idx = cyc - start_cyc;
    if (!reset) begin
      if (!inst[19]) begin
        n_xrd++;
        if (idx == 1) a_x_first = inst[17:7];
      end
      if (inst[2]) begin
        n_l0wr++;
        if (first_l0wr < 0) first_l0wr = idx;
      end
      if (inst[0]) n_load++;
      if (inst[3]) n_l0rd++;
      if (inst[1]) begin
        n_exec++;
        if (first_exec < 0) first_exec = idx;
        last_exec = idx;
      end
      if (inst[6]) begin
        n_ofrd++;
        if (first_ofrd < 0) first_ofrd = idx;
      end
      if (!inst[32] && !inst[31]) begin
        if (n_pwr == 0) first_paddr = inst[30:20];
        last_paddr = inst[30:20];
        if (first_pwr < 0) first_pwr = idx;
        n_pwr++;
      end
      if (done) begin
        n_done++;
        done_idx = idx;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    n_xrd = 0; n_l0wr = 0; n_load = 0; n_l0rd = 0; n_exec = 0;
    n_ofrd = 0; n_pwr = 0; n_done = 0;
    first_l0wr = -1; first_exec = -1; last_exec = -1;
    first_ofrd = -1; first_pwr = -1; done_idx = -1;
    a_x_first = '0; first_paddr = '0; last_paddr = '0;
  endtask

  task automatic start_pass(input logic [3:0] k);
    @(negedge clk); #1;
    clear_mon();
    start = 1'b1;
    kij = k;
    start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    kij = 4'hf;
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk({tag, "_inst"}, inst, IDLE_W);
    chk({tag, "_busy"}, {33'd0, busy}, 34'd0);
    chk({tag, "_done"}, {33'd0, done}, 34'd0);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input bit alt, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (alt) ofifo_valid = ~ofifo_valid;
      if (n_done != 0) break;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_pass(input string tag, input logic [10:0] paddr0);
    chk({tag, "_n_xrd"},  34'(n_xrd),  34'd44);
    chk({tag, "_n_l0wr"}, 34'(n_l0wr), 34'd44);
    chk({tag, "_n_load"}, 34'(n_load), 34'd18);
    chk({tag, "_n_l0rd"}, 34'(n_l0rd), 34'd44);
    chk({tag, "_n_exec"}, 34'(n_exec), 34'd36);
    chk({tag, "_n_ofrd"}, 34'(n_ofrd), 34'd36);
    chk({tag, "_n_pwr"},  34'(n_pwr),  34'd36);
    chk({tag, "_n_done"}, 34'(n_done), 34'd1);
    chk({tag, "_paddr_first"}, 34'(first_paddr), 34'(paddr0));
    chk({tag, "_paddr_last"},  34'(last_paddr),  34'(paddr0 + 11'd35));
  endtask

  // Timing pins for a pass with ofifo_valid held high from the start.
  task automatic check_timing_kij0(input string tag);
    chk({tag, "_ax_first"},   34'(a_x_first),  34'h400);
    chk({tag, "_l0wr_first"}, 34'(first_l0wr), 34'd2);
    chk({tag, "_exec_first"}, 34'(first_exec), 34'd65);
    chk({tag, "_exec_last"},  34'(last_exec),  34'd100);
    chk({tag, "_ofrd_first"}, 34'(first_ofrd), 34'd102);
    chk({tag, "_pwr_first"},  34'(first_pwr),  34'd103);
    chk({tag, "_done_idx"},   34'(done_idx),   34'd139);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    kij = 4'd0;
    ofifo_valid = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    chk("por_inst", inst, IDLE_W);
    chk("por_busy", {33'd0, busy}, 34'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Abort during the weight read phase.
    start_pass(4'd0);
    repeat (4) @(negedge clk);
    async_reset_check("rst_wrd");
    repeat (3) @(negedge clk);

    // Full pass, kij=0, OFIFO always ready.
    ofifo_valid = 1'b1;
    start_pass(4'd0);
    wait_done(1'b0, 300);
    check_pass("k0", 11'd0);
    check_timing_kij0("k0");

    // Drain with alternating stalls, kij=3.
    ofifo_valid = 1'b0;
    start_pass(4'd3);
    wait_done(1'b1, 400);
    check_pass("k3", 11'd108);
    ofifo_valid = 1'b1;

    // Start pulse during EXEC with another kij is ignored.
    start_pass(4'd5);
    repeat (68) @(negedge clk);
    #1;
    start = 1'b1;
    kij = 4'd2;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 300);
    repeat (30) @(negedge clk);
    #1;
    check_pass("k5", 11'd180);

    // Reset in the drain phase after 10 writes, then a fresh pass.
    start_pass(4'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (n_pwr >= 10) break;
    end
    chk("pwr_before_reset", 34'(n_pwr), 34'd10);
    async_reset_check("rst_ofrd");
    repeat (20) @(negedge clk);
    #1;
    chk("pwr_after_reset", 34'(n_pwr), 34'd10);
    chk("done_after_reset", 34'(n_done), 34'd0);

    start_pass(4'd0);
    wait_done(1'b0, 300);
    check_pass("k0b", 11'd0);
    check_timing_kij0("k0b");

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
